// File: rtl/ram256x16_arb.sv
// Two-requester arbiter in front of a simple dual-port RAM. The write and read ports
// are arbitrated independently. Read data returns two cycles after the grant.
module ram256x16_arb #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic          RWCLK,
  input  logic          RESET,
  input  logic          A_REQ,
  input  logic          A_WE,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_WDATA,
  output logic          A_GNT,
  output logic          A_RVALID,
  input  logic          B_REQ,
  input  logic          B_WE,
  input  logic [AW-1:0] B_ADDR,
  input  logic [DW-1:0] B_WDATA,
  output logic          B_GNT,
  output logic          B_RVALID,
  output logic [DW-1:0] RDATA,
  output logic          RAM_WEN,
  output logic          RAM_REN,
  output logic [AW-1:0] RAM_WADDR,
  output logic [AW-1:0] RAM_RADDR,
  output logic [DW-1:0] RAM_WD,
  input  logic [DW-1:0] RAM_RD
);

  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;

  // Grant vector {b, a}; on conflict the requester not recorded in the pointer wins.
  function automatic logic [1:0] arb(input logic a_v, input logic b_v, input req_id_e last);
    logic [1:0] g;
    g = {b_v, a_v};
    if (a_v && b_v) g = (RR_EN && last == REQ_A) ? 2'b10 : 2'b01;
    return g;
  endfunction

  logic    a_wr, a_rd, b_wr, b_rd;
  logic    w_gnt_a, w_gnt_b, r_gnt_a, r_gnt_b;
  logic    bypass;
  req_id_e wptr_q, wptr_d, rptr_q, rptr_d;

  logic          s1_vld_q, s1_byp_q, s2_vld_q;
  req_id_e       s1_own_q, s2_own_q;
  logic [DW-1:0] s1_wd_q, rdata_q;

  assign a_wr = A_REQ &&  A_WE;
  assign a_rd = A_REQ && !A_WE;
  assign b_wr = B_REQ &&  B_WE;
  assign b_rd = B_REQ && !B_WE;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    {w_gnt_b, w_gnt_a} = 2'b00;
    {r_gnt_b, r_gnt_a} = 2'b00;
    wptr_d             = wptr_q;
    rptr_d             = rptr_q;
    if (!RESET) begin
      {w_gnt_b, w_gnt_a} = arb(a_wr, b_wr, wptr_q);
      {r_gnt_b, r_gnt_a} = arb(a_rd, b_rd, rptr_q);
    end
    if (w_gnt_a)      wptr_d = REQ_A;
    else if (w_gnt_b) wptr_d = REQ_B;
    if (r_gnt_a)      rptr_d = REQ_A;
    else if (r_gnt_b) rptr_d = REQ_B;
  end

  assign A_GNT     = w_gnt_a || r_gnt_a;
  assign B_GNT     = w_gnt_b || r_gnt_b;
  assign RAM_WEN   = w_gnt_a || w_gnt_b;
  assign RAM_REN   = r_gnt_a || r_gnt_b;
  assign RAM_WADDR = w_gnt_b ? B_ADDR  : A_ADDR;
  assign RAM_WD    = w_gnt_b ? B_WDATA : A_WDATA;
  assign RAM_RADDR = r_gnt_b ? B_ADDR  : A_ADDR;

  // Same-cycle write/read to one address returns the new data regardless of RAM ordering.
  assign bypass = RAM_WEN && RAM_REN && (RAM_WADDR == RAM_RADDR);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      wptr_q   <= REQ_B;
      rptr_q   <= REQ_B;
      s1_vld_q <= 1'b0;
      s1_own_q <= REQ_A;
      s1_byp_q <= 1'b0;
      s1_wd_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_own_q <= REQ_A;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      s1_vld_q <= RAM_REN;
      s1_own_q <= r_gnt_b ? REQ_B : REQ_A;
      s1_byp_q <= bypass;
      s1_wd_q  <= RAM_WD;
      s2_vld_q <= s1_vld_q;
      s2_own_q <= s1_own_q;
      if (s1_vld_q) rdata_q <= s1_byp_q ? s1_wd_q : RAM_RD;
    end
  end

  assign RDATA    = rdata_q;
  assign A_RVALID = s2_vld_q && (s2_own_q == REQ_A);
  assign B_RVALID = s2_vld_q && (s2_own_q == REQ_B);

endmodule

// File: doc/ram256x16_arb.md
Name: ram256x16_arb

Overview:
- Two-requester arbiter that shares one 256x16 simple dual-port RAM between requester A (e.g. instruction fetch) and requester B (e.g. bus-side load/store).
- The RAM has one write port and one read port on a common clock, so write and read ports are arbitrated independently.
- A read and a write, from the same or different requesters, can issue in the same cycle.
- Sits directly in front of the RAM; requesters never drive the RAM directly.

Parameters:
AW, 8, address width (RAM depth 2**AW)
DW, 16, data width
RR_EN, 1, 1 = round-robin per port; 0 = fixed priority, A always wins

Ports:
RWCLK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-high reset
A_REQ  in  1  A request, held until A_GNT
A_WE  in  1  1 = write, 0 = read; stable while A_REQ
A_ADDR  in  AW  A address; stable while A_REQ
A_WDATA  in  DW  A write data; stable while A_REQ
A_GNT  out  1  combinational grant; request consumed this cycle
A_RVALID  out  1  one-cycle pulse, RDATA holds A's read data
B_REQ, B_WE, B_ADDR, B_WDATA, B_GNT, B_RVALID: as A, for requester B
RDATA  out  DW  registered read data, shared by both requesters
RAM_WEN  out  1  RAM write strobe
RAM_REN  out  1  RAM read strobe
RAM_WADDR  out  AW  RAM write address
RAM_RADDR  out  AW  RAM read address
RAM_WD  out  DW  RAM write data
RAM_RD  in  DW  RAM read data, valid 1 cycle after RAM_REN

Behaviour:
- Reset values: A_GNT, B_GNT, RAM_WEN and RAM_REN are forced 0 while RESET=1. A_RVALID=0, B_RVALID=0, RDATA=0. Write and read priority pointers point at B, so A wins the first conflict.
- Port request classification: write-port requesters have REQ=1 and WE=1; read-port requesters have REQ=1 and WE=0.
- Per-port arbitration is combinational in the same cycle:
  - One requester on a port: it is granted.
  - Both requesters on a port with RR_EN=1: the one not recorded in that port's pointer is granted.
  - Both requesters on a port with RR_EN=0: A is granted.
- Pointer update: a port's pointer loads the granted requester's ID on every grant on that port. Ports with no grant hold their pointer.
- At most one grant per requester per cycle, because a requester presents one operation.
- Write issue (cycle T0): RAM_WEN=1; RAM_WADDR and RAM_WD are muxed from the winner. The write is complete at the T0 edge. No response is returned for writes.
- Read pipeline:
  - T0: RAM_REN=1 and RAM_RADDR is muxed from the winner. Owner ID, bypass flag and RAM_WD are registered.
  - T1: RDATA loads (bypass ? registered WD : RAM_RD) at the end of T1.
  - T2: the owner's RVALID is high for exactly one cycle.
  - Latency is 2 cycles from grant to RVALID. Throughput is one read per cycle, pipelined.
- Bypass: if in T0 a write and a read are both granted with RAM_WADDR == RAM_RADDR, the read returns the new write data. This holds whatever the RAM's collision behaviour (write-first ordering is guaranteed by the arbiter).
- RDATA holds its value between RVALID pulses.
- Ungranted requester keeps REQ asserted. No request is dropped or duplicated.
- With RR_EN=1, worst-case wait is 1 cycle per port under continuous contention.
- Changing WE, ADDR or WDATA while REQ=1 and before GNT: illegal. The bench checks requester compliance; the arbiter does not detect it.
- RESET asserted mid-operation: in-flight reads are discarded, no RVALID is produced for them, pointers return to reset value, RDATA is cleared.
- Address wrap: none; addresses are AW bits, full range 0..2**AW-1 valid.

Test Plan:
- Reset, then A reads addr 0x05 after B wrote 0x05=0xBEEF in a prior cycle -> A_GNT same cycle, A_RVALID 2 cycles later with RDATA=0xBEEF, B_RVALID stays 0.
- A and B both write continuously, A writes 0x10..0x13 and B writes 0x20..0x23, RR_EN=1 -> grants alternate A,B,A,B..., first grant A. Readback confirms all 8 words.
- Same cycle: A writes 0x40=0x1234, B reads 0x40 (old value 0x0000) -> both granted, B_RVALID at T2 with RDATA=0x1234 (bypass).
- Back-to-back reads A@0x01, B@0x02, A@0x03 with RAM preloaded 0x1111/0x2222/0x3333 -> RVALID pulses A,B,A on consecutive cycles with matching data, no gaps.
- RR_EN=0, both request reads continuously for 4 cycles -> A granted every cycle, B_GNT=0 throughout until A_REQ drops, then B granted next cycle.
- RESET pulsed one cycle after a read grant -> no RVALID produced, RDATA=0, next conflict grants A.
